serial_op_sequencer: RTL
========================

// Module: serial_op_sequencer
// PURPOSE
// - Control FSM for a multicycle serial datapath (shift-add multiplier / restoring divider).
// - Takes a start pulse and loads operands. Issues exactly ITERATIONS step strobes, skipping stalled cycles.
// - Then raises a one-cycle done pulse.
// - Sits between the CPU control unit and the serial unit; owns the iteration count and last-step flag.
// PARAMETERS
// - ITERATIONS   32                      number of step cycles per operation, >= 2
// - NBITS        CeilLog2(ITERATIONS)    width of iter_count (local function, same form as codebase)
// PORTS
// - clk         in   1      system clock; all state updates on posedge clk
// - reset       in   1      asynchronous, active-low reset
// - start       in   1      request new operation; sampled only in IDLE
// - abort       in   1      synchronous cancel; honoured in LOAD and RUN
// - stall       in   1      datapath not ready; freezes RUN for that cycle
// - load_en     out  1      one-cycle strobe: datapath captures operands
// - step_en     out  1      datapath performs one iteration this cycle
// - iter_count  out  NBITS  index of the current iteration, 0..ITERATIONS-1
// - last_iter   out  1      high while iter_count == ITERATIONS-1 in RUN
// - busy        out  1      high in LOAD and RUN
// - done        out  1      one-cycle pulse: result valid in the datapath
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, iter_count=0.
//   Every output is 0 during reset and on the first cycle after release.
// - States, encoded 2 bits: IDLE=0, LOAD=1, RUN=2, DONE=3.
// - IDLE: outputs low.
//   - start=1 -> LOAD next cycle.
//   - start held high is not re-sampled until the next return to IDLE.
// - LOAD: load_en=1, busy=1, iter_count forced to 0.
//   - abort=1 -> IDLE.
//   - otherwise -> RUN.
//   - Lasts exactly 1 cycle.
// - RUN: busy=1; step_en = ~stall & ~abort.
//   - On a cycle with step_en=1: if iter_count==ITERATIONS-1 -> DONE and iter_count wraps to 0; else iter_count+1.
//   - stall=1: iter_count, state and last_iter hold; step_en=0.
//   - abort=1 (stall irrelevant): -> IDLE, iter_count=0, no done pulse.
// - DONE: done=1, busy=0, step_en=0. Unconditionally -> IDLE after 1 cycle.
//   - start in DONE is ignored.
//   - Minimum start-to-start spacing is therefore ITERATIONS+3 cycles.
// - Latency: start at cycle t, no stall -> load_en at t+1, step_en at t+2..t+1+ITERATIONS, done at t+2+ITERATIONS.
//   Each stall cycle adds 1.
// - Outputs are Moore-decoded from registered state, except step_en.
//   step_en is combinational from state, stall and abort.
// - iter_count is unsigned NBITS and never exceeds ITERATIONS-1. Compare against ITERATIONS-1 sized to NBITS.
// - Async reset mid-RUN: immediate return to IDLE, count 0. The datapath result is discarded.
// - Illegal state code: not reachable with 4 states; default branch -> IDLE.
// STRUCTURE
// - Shared package/header: state encodings (SEQ_IDLE..SEQ_DONE) and the CeilLog2 function.
// - One sub-module, seq_iter_counter.
//   - Posedge counter with clear, enable and wrap at ITERATIONS-1.
//   - Outputs count and terminal flag.
// - The FSM drives: clear=LOAD|abort, enable=step_en.
// TESTING
// - ITERATIONS=4, start pulse at cycle 0, stall=0.
//   Required: load_en@1; step_en@2..5 with iter_count 0,1,2,3; last_iter@5; done@6; busy 1..5.
// - ITERATIONS=4, stall=1 on cycles 3 and 4.
//   Required: iter_count holds at 1 on both cycles; done moves to cycle 8; exactly 4 step_en strobes.
// - abort=1 at the RUN cycle with iter_count=2.
//   Required: next cycle IDLE; iter_count=0; no done; step_en=0 on the abort cycle.
// - start held high continuously.
//   Required: back-to-back operations with load_en every ITERATIONS+3 cycles; start ignored in DONE.
// - reset deasserted -> asserted low mid-RUN (iter_count=3).
//   Required: all outputs 0 immediately, asynchronously; after release, IDLE until the next start.
// - ITERATIONS=32, random stall pattern.
//   Required: exactly 32 step_en per operation; iter_count never exceeds 31; done exactly once per start.

Source files
------------

// File: rtl/serial_op_sequencer_pkg.sv
// Shared definitions for the serial op sequencer slice.
//   seq_state_e : 2-bit FSM state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   CeilLog2    : width helper for the iteration counter
package serial_op_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_LOAD = 2'd1,
    SEQ_RUN  = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_e;

  // Smallest r with 2**r >= n. Callers always pass n >= 2, so r >= 1.
  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_op_sequencer_if.sv
// Control bus between the CPU control unit (master) and the sequencer (slave).
//   start/abort/stall         : master -> sequencer
//   load_en/step_en/iter_count/
//   last_iter/busy/done       : sequencer -> master / datapath
interface serial_op_sequencer_if
  import serial_op_sequencer_pkg::*;
#(
  parameter int ITERATIONS = 32
);
  localparam int NBITS = CeilLog2(ITERATIONS);

  logic             start;
  logic             abort;
  logic             stall;
  logic             load_en;
  logic             step_en;
  logic [NBITS-1:0] iter_count;
  logic             last_iter;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, stall,
    input  load_en, step_en, iter_count, last_iter, busy, done
  );

  modport slave (
    input  start, abort, stall,
    output load_en, step_en, iter_count, last_iter, busy, done
  );
endinterface

// File: rtl/serial_op_sequencer_counter.sv
// Iteration counter for the sequencer.
//   clk, reset : clock, async active-low reset
//   clear      : force count to 0 (wins over enable)
//   enable     : advance one step; wraps to 0 after ITERATIONS-1
//   count      : current iteration index
//   terminal   : count == ITERATIONS-1
module seq_iter_counter
  import serial_op_sequencer_pkg::*;
#(
  parameter int ITERATIONS = 32,
  parameter int NBITS      = CeilLog2(ITERATIONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [NBITS-1:0] count,
  output logic             terminal
);
  localparam logic [NBITS-1:0] LAST = NBITS'(ITERATIONS - 1);

  assign terminal = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= terminal ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/serial_op_sequencer.sv
// Control FSM for a multicycle serial datapath (shift-add mul / restoring div).
// A start in IDLE loads operands for one cycle, then issues exactly ITERATIONS
// step strobes (stalled cycles skipped), then pulses done for one cycle.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of serial_op_sequencer_if
// All outputs are decoded from registered state except step_en, which also
// depends on stall/abort in the current cycle.
module serial_op_sequencer
  import serial_op_sequencer_pkg::*;
#(
  parameter int ITERATIONS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_op_sequencer_if.slave  bus
);
  localparam int NBITS = CeilLog2(ITERATIONS);

  seq_state_e       state, state_nxt;
  logic             step_en;
  logic             clear;
  logic             terminal;
  logic [NBITS-1:0] count;

  assign step_en = (state == SEQ_RUN) & ~bus.stall & ~bus.abort;
  // Abort clears the count in any state; outside RUN/LOAD it is already 0.
  assign clear   = (state == SEQ_LOAD) | bus.abort;

  seq_iter_counter #(.ITERATIONS(ITERATIONS), .NBITS(NBITS)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .enable   (step_en),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEQ_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE: if (bus.start) state_nxt = SEQ_LOAD;
      SEQ_LOAD: state_nxt = bus.abort ? SEQ_IDLE : SEQ_RUN;
      SEQ_RUN: begin
        if (bus.abort)               state_nxt = SEQ_IDLE;
        else if (step_en && terminal) state_nxt = SEQ_DONE;
      end
      SEQ_DONE: state_nxt = SEQ_IDLE;
      default:  state_nxt = SEQ_IDLE;
    endcase
  end

  assign bus.load_en    = (state == SEQ_LOAD);
  assign bus.step_en    = step_en;
  assign bus.iter_count = count;
  assign bus.last_iter  = (state == SEQ_RUN) & terminal;
  assign bus.busy       = (state == SEQ_LOAD) | (state == SEQ_RUN);
  assign bus.done       = (state == SEQ_DONE);
endmodule
